// File: rtl/uart_tick_tx_pkg.sv
// Shared peripheral package for the tick-driven UART transmitter:
// default parameters, frame FSM state encoding and the top-level register list.
package uart_tick_tx_pkg;

    localparam int CFifoWDef    = 2;
    localparam int CStopBitsDef = 1;

    localparam logic [1:0] CStIdle  = 2'd0;
    localparam logic [1:0] CStStart = 2'd1;
    localparam logic [1:0] CStData  = 2'd2;
    localparam logic [1:0] CStStop  = 2'd3;

    typedef struct packed {
        logic [1:0] state;
        logic [2:0] bitCnt;
        logic       stopCnt;
        logic [7:0] shift;
        logic       txD;
        logic       overflow;
    } TxRegsT;

    localparam TxRegsT CTxRegsReset = '{
        state:    CStIdle,
        bitCnt:   3'd0,
        stopCnt:  1'b0,
        shift:    8'd0,
        txD:      1'b1,
        overflow: 1'b0
    };

endpackage

// File: rtl/uart_tick_fifo.sv
// Byte FIFO feeding the transmitter: 2**CFifoW entries, wrapping pointers,
// CFifoW+1 bit occupancy count. Writes into a full FIFO are ignored.
module uart_tick_fifo
    import uart_tick_tx_pkg::*;
#(
    parameter int CFifoW = CFifoWDef
) (
    input  logic       AClkH,
    input  logic       AResetHN,
    input  logic       AClkHEn,
    input  logic [7:0] AWrData,
    input  logic       AWrStrobe,
    input  logic       ARdStrobe,
    output logic [7:0] ARdData,
    output logic       AFull,
    output logic       AEmpty
);

    localparam int CDepth = 1 << CFifoW;

    logic [7:0]        mem [CDepth];
    logic [CFifoW-1:0] wrPtr;
    logic [CFifoW-1:0] rdPtr;
    logic [CFifoW:0]   count;
    logic              push;
    logic              pop;

    assign push = AClkHEn & AWrStrobe & ~AFull;
    assign pop  = AClkHEn & ARdStrobe & ~AEmpty;

    // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge AClkH) begin
        if (push) begin
            mem[wrPtr] <= AWrData;
        end
    end

    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + (CFifoW+1)'(push) - (CFifoW+1)'(pop);
        end
    end

    assign ARdData = mem[rdPtr];
    assign AFull   = (count == (CFifoW+1)'(CDepth));
    assign AEmpty  = (count == '0);

endmodule

// File: rtl/uart_tick_tx.sv
// UART transmitter paced by an external bit tick: 8N1/8N2 frames drained
// back-to-back from a small byte FIFO, with a registered serial output.
module uart_tick_tx
    import uart_tick_tx_pkg::*;
#(
    parameter int CFifoW    = CFifoWDef,
    parameter int CStopBits = CStopBitsDef
) (
    input  logic       AClkH,
    input  logic       AResetHN,
    input  logic       AClkHEn,
    input  logic       ABitTick,
    input  logic [7:0] AWrData,
    input  logic       AWrStrobe,
    output logic       AFull,
    output logic       AOverflow,
    output logic       ABusy,
    output logic       ATxD
);

    localparam logic CStopLast = 1'(CStopBits - 1);

    TxRegsT     r;
    TxRegsT     rNext;
    logic       pop;
    logic       fifoEmpty;
    logic [7:0] headData;

    uart_tick_fifo #(
        .CFifoW(CFifoW)
    ) fifo (
        .AClkH    (AClkH),
        .AResetHN (AResetHN),
        .AClkHEn  (AClkHEn),
        .AWrData  (AWrData),
        .AWrStrobe(AWrStrobe),
        .ARdStrobe(pop),
        .ARdData  (headData),
        .AFull    (AFull),
        .AEmpty   (fifoEmpty)
    );

    // NOTE: every field starts from its current value so no path through the case infers a latch.
    always_comb begin
        rNext          = r;
        pop            = 1'b0;
        rNext.overflow = AWrStrobe & AFull;
        if (ABitTick) begin
            case (r.state)
                CStIdle: begin
                    if (!fifoEmpty) begin
                        pop         = 1'b1;
                        rNext.shift = headData;
                        rNext.state = CStStart;
                        rNext.txD   = 1'b0;
                    end
                end
                CStStart: begin
                    rNext.state  = CStData;
                    rNext.bitCnt = 3'd0;
                    rNext.txD    = r.shift[0];
                end
                CStData: begin
                    if (r.bitCnt == 3'd7) begin
                        rNext.state   = CStStop;
                        rNext.stopCnt = 1'b0;
                        rNext.txD     = 1'b1;
                    end else begin
                        rNext.shift  = r.shift >> 1;
                        rNext.txD    = r.shift[1];
                        rNext.bitCnt = r.bitCnt + 3'd1;
                    end
                end
                CStStop: begin
                    // Chain straight into the next start bit so queued frames leave no idle gap.
                    if (r.stopCnt == CStopLast) begin
                        if (!fifoEmpty) begin
                            pop         = 1'b1;
                            rNext.shift = headData;
                            rNext.state = CStStart;
                            rNext.txD   = 1'b0;
                        end else begin
                            rNext.state = CStIdle;
                        end
                    end else begin
                        rNext.stopCnt = r.stopCnt + 1'b1;
                    end
                end
                default: rNext.state = CStIdle;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            r <= CTxRegsReset;
        end else if (AClkHEn) begin
            r <= rNext;
        end
    end

    assign ATxD      = r.txD;
    assign AOverflow = r.overflow;
    assign ABusy     = (r.state != CStIdle) | ~fifoEmpty;

endmodule

// File: tb/tb_uart_tick_tx.sv
// Scoreboard bench: two transmitters (1 and 2 stop bits) share stimulus; a line
// receiver per instance decodes frames and compares them against queued bytes.
module tb_uart_tick_tx;

    localparam int CDepth = 4;

    logic       AClkH = 1'b0;
    logic       AResetHN;
    logic       AClkHEn;
    logic       ABitTick;
    logic [7:0] AWrData;
    logic       AWrStrobe;
    logic [1:0] full;
    logic [1:0] ovf;
    logic [1:0] busy;
    logic [1:0] txd;

    uart_tick_tx #(.CFifoW(2), .CStopBits(1)) dutS1 (
        .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn), .ABitTick(ABitTick),
        .AWrData(AWrData), .AWrStrobe(AWrStrobe), .AFull(full[0]), .AOverflow(ovf[0]),
        .ABusy(busy[0]), .ATxD(txd[0])
    );

    uart_tick_tx #(.CFifoW(2), .CStopBits(2)) dutS2 (
        .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn), .ABitTick(ABitTick),
        .AWrData(AWrData), .AWrStrobe(AWrStrobe), .AFull(full[1]), .AOverflow(ovf[1]),
        .ABusy(busy[1]), .ATxD(txd[1])
    );

    initial forever #5 AClkH = ~AClkH;

    int         checkCnt = 0;
    int         passCnt  = 0;
    int         tickPeriod = 4;
    bit         tickOn = 0;
    bit         enRand = 0;
    bit         enHold = 0;
    bit         monOn  = 0;
    logic [7:0] expList[$];
    logic [7:0] burst[$];
    int         idx[2]       = '{0, 0};
    int         rxPhase[2]   = '{0, 0};
    int         rxBit[2]     = '{0, 0};
    int         rxStop[2]    = '{0, 0};
    logic [7:0] rxByte[2];
    bit         needStart[2] = '{0, 0};
    bit         pendIdle[2]  = '{0, 0};
    int         ovfCnt[2]    = '{0, 0};
    int         glitchCnt[2] = '{0, 0};
    logic       prevTxd[2]   = '{1'b1, 1'b1};
    bit         prevTick = 0;

    task automatic check(input string name, input int act, input int exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge AClkH);
        #1;
    endtask

    // Tick generator and clock-enable driver.
    initial begin
        int cnt;
        cnt = 0;
        ABitTick = 1'b0;
        AClkHEn  = 1'b1;
        forever begin
            cycle();
            if (tickOn) begin
                cnt = (cnt + 1 >= tickPeriod) ? 0 : cnt + 1;
                ABitTick = (cnt == 0);
            end else begin
                cnt = 0;
                ABitTick = 1'b0;
            end
            if (enHold) AClkHEn = 1'b0;
            else if (enRand) AClkHEn = ($urandom_range(0, 7) != 0);
            else AClkHEn = 1'b1;
        end
    end

    // Line receiver: one sample per accepted tick = the level of the interval that tick closes.
    task automatic rx_sample(input int k, input logic s);
        int nStop;
        nStop = (k == 0) ? 1 : 2;
        case (rxPhase[k])
            0: begin
                if (needStart[k]) begin
                    check($sformatf("back_to_back_start_dut%0d", k), int'(s), 0);
                    needStart[k] = 0;
                end
                if (s == 1'b0) begin
                    check($sformatf("start_has_queued_byte_dut%0d", k), int'(idx[k] < expList.size()), 1);
                    rxPhase[k] = 1;
                    rxBit[k]   = 0;
                    rxByte[k]  = 8'h00;
                end
            end
            1: begin
                rxByte[k] = {s, rxByte[k][7:1]};
                rxBit[k]++;
                if (rxBit[k] == 8) begin
                    rxPhase[k] = 2;
                    rxStop[k]  = 0;
                end
            end
            default: begin
                check($sformatf("stop_level_dut%0d", k), int'(s), 1);
                rxStop[k]++;
                if (rxStop[k] == nStop) begin
                    if (idx[k] < expList.size()) begin
                        check($sformatf("rx_byte_dut%0d_n%0d", k, idx[k]), int'(rxByte[k]), int'(expList[idx[k]]));
                        idx[k]++;
                    end
                    rxPhase[k]   = 0;
                    needStart[k] = (idx[k] < expList.size());
                    pendIdle[k]  = !needStart[k];
                end
            end
        endcase
    endtask

    initial begin
        forever begin
            @(negedge AClkH);
            if (monOn) begin
                for (int k = 0; k < 2; k++) begin
                    if (ovf[k]) ovfCnt[k]++;
                    if (!prevTick && txd[k] !== prevTxd[k]) glitchCnt[k]++;
                    prevTxd[k] = txd[k];
                    if (pendIdle[k]) begin
                        check($sformatf("busy_low_after_last_frame_dut%0d", k), int'(busy[k]), 0);
                        pendIdle[k] = 0;
                    end
                    if (AClkHEn && ABitTick) rx_sample(k, txd[k]);
                end
                prevTick = AClkHEn && ABitTick;
            end
        end
    end

    task automatic mon_clear();
        for (int k = 0; k < 2; k++) begin
            rxPhase[k]   = 0;
            rxBit[k]     = 0;
            rxStop[k]    = 0;
            idx[k]       = expList.size();
            needStart[k] = 0;
            pendIdle[k]  = 0;
            prevTxd[k]   = 1'b1;
        end
        prevTick = 0;
    endtask

    // Write the burst on consecutive cycles with ticks stopped; the model accepts the first CDepth.
    task automatic run_burst();
        int acc   = 0;
        int drops = 0;
        int base0 = ovfCnt[0];
        int base1 = ovfCnt[1];
        tickOn = 0;
        enRand = 0;
        enHold = 0;
        repeat (2) cycle();
        foreach (burst[i]) begin
            AWrData   = burst[i];
            AWrStrobe = 1'b1;
            if (acc < CDepth) begin
                expList.push_back(burst[i]);
                acc++;
            end else begin
                drops++;
            end
            cycle();
            check($sformatf("full_after_write%0d_dut0", i), int'(full[0]), int'(acc == CDepth));
            check($sformatf("full_after_write%0d_dut1", i), int'(full[1]), int'(acc == CDepth));
        end
        AWrStrobe = 1'b0;
        repeat (2) cycle();
        check("overflow_pulses_dut0", ovfCnt[0] - base0, drops);
        check("overflow_pulses_dut1", ovfCnt[1] - base1, drops);
    endtask

    task automatic drain(input bit randEn);
        bit done = 0;
        tickOn = 1;
        enRand = randEn;
        for (int c = 0; c < 4000 && !done; c++) begin
            cycle();
            done = (idx[0] == expList.size()) && (idx[1] == expList.size()) &&
                   (busy == 2'b00) && (rxPhase[0] == 0) && (rxPhase[1] == 0);
        end
        enRand = 0;
        enHold = 0;
        check("drain_done", int'(done), 1);
        repeat (2) cycle();
    endtask

    task automatic wait_rx_bit(input int b);
        bit found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            cycle();
            found = (rxPhase[0] == 1) && (rxBit[0] == b);
        end
        check($sformatf("reached_data_bit%0d", b), int'(found), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        AResetHN  = 1'b0;
        AWrStrobe = 1'b0;
        AWrData   = 8'h00;
        repeat (3) cycle();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_txd_dut%0d", k), int'(txd[k]), 1);
            check($sformatf("reset_busy_dut%0d", k), int'(busy[k]), 0);
            check($sformatf("reset_full_dut%0d", k), int'(full[k]), 0);
            check($sformatf("reset_ovf_dut%0d", k), int'(ovf[k]), 0);
        end
        AResetHN = 1'b1;
        mon_clear();
        monOn = 1;

        // Single frame, tick every 4 cycles.
        tickPeriod = 4;
        burst = '{8'hA5};
        run_burst();
        drain(0);

        // Two frames chained without an idle interval.
        burst = '{8'h00, 8'hFF};
        run_burst();
        drain(0);

        // Five writes with no ticks: fifth is dropped.
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_burst();
        drain(0);

        // Two stop-bit style check plus enable held low across two ticks mid-frame.
        tickPeriod = 5;
        burst = '{8'h55, 8'h96};
        run_burst();
        tickOn = 1;
        wait_rx_bit(4);
        enHold = 1;
        repeat (2 * 5 + 1) cycle();
        enHold = 0;
        drain(0);

        // Reset during data bit 3 of 0x3C with two more bytes queued.
        tickPeriod = 4;
        burst = '{8'h3C, 8'h5A, 8'hC3};
        run_burst();
        tickOn = 1;
        wait_rx_bit(3);
        AResetHN = 1'b0;
        #1;
        tickOn = 0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("abort_txd_dut%0d", k), int'(txd[k]), 1);
            check($sformatf("abort_busy_dut%0d", k), int'(busy[k]), 0);
            check($sformatf("abort_full_dut%0d", k), int'(full[k]), 0);
        end
        mon_clear();
        repeat (3) cycle();
        AResetHN = 1'b1;
        tickOn = 1;
        repeat (160) cycle();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("post_abort_idle_txd_dut%0d", k), int'(txd[k]), 1);
            check($sformatf("post_abort_idle_busy_dut%0d", k), int'(busy[k]), 0);
        end

        // Randomised bursts, tick rates and clock-enable gaps.
        for (int t = 0; t < 12; t++) begin
            int n;
            tickPeriod = $urandom_range(2, 7);
            n = $urandom_range(1, 6);
            burst.delete();
            for (int i = 0; i < n; i++) burst.push_back(8'($urandom_range(0, 255)));
            run_burst();
            drain(1'($urandom_range(0, 1)));
        end

        check("txd_stable_between_ticks_dut0", glitchCnt[0], 0);
        check("txd_stable_between_ticks_dut1", glitchCnt[1], 0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
